// File: rtl/trace_exit_collector.sv
// trace_exit_collector: central collector of per-core OR1K exit events (l.nop 0x1).
// It latches sticky exit flags and the first failing core and its code. It then
// sequences RUN -> DRAIN -> DONE, or RUN -> TIMEOUT when the monitored cores stay idle.
module trace_exit_collector #(
    parameter int NUM_CORES       = 100,
    parameter int CORE_ID_WIDTH   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    parameter int TERM_MODE       = 0,
    parameter int DRAIN_CYCLES    = 16,
    parameter int WATCHDOG_CYCLES = 1000000,
    parameter int WATCHDOG_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CORES-1:0]      trace_valid,
    input  logic [32*NUM_CORES-1:0]   trace_insn,
    input  logic [32*NUM_CORES-1:0]   trace_r3,
    input  logic [NUM_CORES-1:0]      term_mask,
    output logic [NUM_CORES-1:0]      terminated,
    output logic [CORE_ID_WIDTH:0]    num_terminated,
    output logic                      fail,
    output logic [CORE_ID_WIDTH-1:0]  fail_id,
    output logic [31:0]               fail_code,
    output logic                      done,
    output logic                      timeout,
    output logic [1:0]                state
);

    // state   | meaning
    // RUN     | waiting for the completion condition, watchdog counting idle cycles
    // DRAIN   | completion seen, letting trailing trace output settle
    // DONE    | simulation finished (absorbing until rst)
    // TIMEOUT | no masked-in activity for WATCHDOG_CYCLES (absorbing until rst)
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DRAIN   = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    localparam logic [31:0] EXIT_INSN = 32'h1500_0001;

    localparam int DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DRAIN_LAST_I = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LAST_I);

    localparam int WD_LAST_I = (WATCHDOG_CYCLES > 0) ? WATCHDOG_CYCLES - 1 : 0;
    localparam logic [WATCHDOG_WIDTH-1:0] WD_LAST = WATCHDOG_WIDTH'(WD_LAST_I);

    state_t                     state_q, state_d;
    logic [NUM_CORES-1:0]       terminated_q, terminated_d;
    logic [CORE_ID_WIDTH:0]     num_term_q, num_term_d;
    logic                       fail_q, fail_d;
    logic [CORE_ID_WIDTH-1:0]   fail_id_q, fail_id_d;
    logic [31:0]                fail_code_q, fail_code_d;
    logic [WATCHDOG_WIDTH-1:0]  wd_q, wd_d;
    logic [DRAIN_W-1:0]         drain_q, drain_d;

    logic [NUM_CORES-1:0]       exit_ev;
    logic [NUM_CORES-1:0]       fail_ev;
    logic                       activity;
    logic                       complete;
    logic [CORE_ID_WIDTH-1:0]   first_id;
    logic [31:0]                first_code;

    // Per-core exit/failure detection plus the aggregate activity and completion terms.
    always_comb begin
        exit_ev = '0;
        fail_ev = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            exit_ev[i] = trace_valid[i] && (trace_insn[32*i +: 32] == EXIT_INSN) &&
                         term_mask[i] && !terminated_q[i];
            fail_ev[i] = exit_ev[i] && (trace_r3[32*i +: 32] != 32'd0);
        end
        activity = |(trace_valid & term_mask & ~terminated_q);
        if (TERM_MODE == 0) begin
            complete = ((terminated_q & term_mask) == term_mask);
        end else begin
            complete = |(terminated_q & term_mask);
        end
    end

    // Sticky exit flags, their popcount and the first-failure capture (lowest index wins).
    always_comb begin
        terminated_d = terminated_q | exit_ev;
        num_term_d   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            num_term_d = num_term_d + (CORE_ID_WIDTH+1)'(terminated_d[i]);
        end
        first_id   = '0;
        first_code = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (fail_ev[i]) begin
                first_id   = CORE_ID_WIDTH'(i);
                first_code = trace_r3[32*i +: 32];
            end
        end
        fail_d      = fail_q;
        fail_id_d   = fail_id_q;
        fail_code_d = fail_code_q;
        if (!fail_q && (|fail_ev)) begin
            fail_d      = 1'b1;
            fail_id_d   = first_id;
            fail_code_d = first_code;
        end
    end

    // Watchdog counts idle RUN cycles (saturating); drain counter runs only in DRAIN.
    always_comb begin
        wd_d    = wd_q;
        drain_d = '0;
        if (state_q == S_RUN) begin
            if (activity) begin
                wd_d = '0;
            end else if (wd_q != {WATCHDOG_WIDTH{1'b1}}) begin
                wd_d = wd_q + 1'b1;
            end
        end
        if (state_q == S_DRAIN) begin
            drain_d = drain_q + 1'b1;
        end
    end

    // Next-state logic; completion takes priority over the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (complete) begin
                    state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                end else if ((WATCHDOG_CYCLES > 0) && (wd_q == WD_LAST) && !activity) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: exit flags, failure capture and both counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            terminated_q <= '0;
            num_term_q   <= '0;
            fail_q       <= 1'b0;
            fail_id_q    <= '0;
            fail_code_q  <= '0;
            wd_q         <= '0;
            drain_q      <= '0;
        end else begin
            terminated_q <= terminated_d;
            num_term_q   <= num_term_d;
            fail_q       <= fail_d;
            fail_id_q    <= fail_id_d;
            fail_code_q  <= fail_code_d;
            wd_q         <= wd_d;
            drain_q      <= drain_d;
        end
    end

    // Output decode; everything is driven from registers only.
    always_comb begin
        terminated     = terminated_q;
        num_terminated = num_term_q;
        fail           = fail_q;
        fail_id        = fail_id_q;
        fail_code      = fail_code_q;
        state          = state_q;
        done           = (state_q == S_DONE);
        timeout        = (state_q == S_TIMEOUT);
    end

endmodule

// File: tb/tb_trace_exit_collector.sv
// Bench for trace_exit_collector: three configurations share one trace stream and
// are checked every cycle against a timestamp-based model. Directed scenarios add
// hand-computed literal checks.
module tb_trace_exit_collector;

    localparam int NC   = 4;
    localparam int NCFG = 3;
    localparam int MD [NCFG] = '{0, 1, 0};
    localparam int DR [NCFG] = '{16, 3, 0};
    localparam int WD [NCFG] = '{100, 200, 0};
    localparam logic [31:0] EXIT = 32'h1500_0001;

    logic clk = 1'b0;
    logic rst;
    logic [NC-1:0]    tv;
    logic [32*NC-1:0] ti, tr;
    logic [NC-1:0]    msk     [NCFG];

    logic [NC-1:0]    o_term  [NCFG];
    logic [2:0]       o_num   [NCFG];
    logic             o_fail  [NCFG];
    logic [1:0]       o_fid   [NCFG];
    logic [31:0]      o_fcode [NCFG];
    logic             o_done  [NCFG];
    logic             o_to    [NCFG];
    logic [1:0]       o_st    [NCFG];

    always #5 clk = ~clk;

    trace_exit_collector #(.NUM_CORES(NC), .TERM_MODE(MD[0]), .DRAIN_CYCLES(DR[0]),
                           .WATCHDOG_CYCLES(WD[0]), .WATCHDOG_WIDTH(32)) u0 (
        .clk(clk), .rst(rst), .trace_valid(tv), .trace_insn(ti), .trace_r3(tr),
        .term_mask(msk[0]), .terminated(o_term[0]), .num_terminated(o_num[0]),
        .fail(o_fail[0]), .fail_id(o_fid[0]), .fail_code(o_fcode[0]),
        .done(o_done[0]), .timeout(o_to[0]), .state(o_st[0]));

    trace_exit_collector #(.NUM_CORES(NC), .TERM_MODE(MD[1]), .DRAIN_CYCLES(DR[1]),
                           .WATCHDOG_CYCLES(WD[1]), .WATCHDOG_WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .trace_valid(tv), .trace_insn(ti), .trace_r3(tr),
        .term_mask(msk[1]), .terminated(o_term[1]), .num_terminated(o_num[1]),
        .fail(o_fail[1]), .fail_id(o_fid[1]), .fail_code(o_fcode[1]),
        .done(o_done[1]), .timeout(o_to[1]), .state(o_st[1]));

    trace_exit_collector #(.NUM_CORES(NC), .TERM_MODE(MD[2]), .DRAIN_CYCLES(DR[2]),
                           .WATCHDOG_CYCLES(WD[2]), .WATCHDOG_WIDTH(8)) u2 (
        .clk(clk), .rst(rst), .trace_valid(tv), .trace_insn(ti), .trace_r3(tr),
        .term_mask(msk[2]), .terminated(o_term[2]), .num_terminated(o_num[2]),
        .fail(o_fail[2]), .fail_id(o_fid[2]), .fail_code(o_fcode[2]),
        .done(o_done[2]), .timeout(o_to[2]), .state(o_st[2]));

    // Model: exit flags and failure as plain sets; the state machine is expressed
    // as timestamps (cycle the completion condition was seen, cycle the idle limit hit).
    logic [NC-1:0] m_term  [NCFG];
    bit            m_fail  [NCFG];
    int            m_fid   [NCFG];
    logic [31:0]   m_fcode [NCFG];
    int            cond_at [NCFG];
    int            to_at   [NCFG];
    int            quiet_from [NCFG];
    int            cyc;

    int n_vec = 0;
    int n_err = 0;

    function automatic int exp_state(int c);
        if (cond_at[c] >= 0) return (cyc >= cond_at[c] + 1 + DR[c]) ? 2 : 1;
        if (to_at[c] >= 0) return 3;
        return 0;
    endfunction

    task automatic chk(string name, int c, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cfg%0d cyc%0d: got %0h expected %0h", name, c, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCFG; c++) begin
            chk("terminated", c, o_term[c], m_term[c]);
            chk("num_terminated", c, o_num[c], $countones(m_term[c]));
            chk("fail", c, o_fail[c], m_fail[c]);
            chk("fail_id", c, o_fid[c], m_fid[c]);
            chk("fail_code", c, o_fcode[c], m_fcode[c]);
            chk("state", c, o_st[c], exp_state(c));
            chk("done", c, o_done[c], exp_state(c) == 2);
            chk("timeout", c, o_to[c], exp_state(c) == 3);
        end
    endtask

    task automatic model_update();
        bit cmp, act, ev;
        if (rst) begin
            for (int c = 0; c < NCFG; c++) begin
                m_term[c] = '0; m_fail[c] = 0; m_fid[c] = 0; m_fcode[c] = '0;
                cond_at[c] = -1; to_at[c] = -1; quiet_from[c] = 0;
            end
            cyc = 0;
            return;
        end
        for (int c = 0; c < NCFG; c++) begin
            if (exp_state(c) == 0) begin
                cmp = (MD[c] == 0) ? ((m_term[c] & msk[c]) == msk[c]) : (|(m_term[c] & msk[c]));
                act = |(tv & msk[c] & ~m_term[c]);
                if (cmp) cond_at[c] = cyc;
                else if (WD[c] > 0) begin
                    if (act) quiet_from[c] = cyc + 1;
                    else if (cyc - quiet_from[c] == WD[c] - 1) to_at[c] = cyc;
                end
            end
            for (int i = 0; i < NC; i++) begin
                ev = tv[i] && (ti[32*i +: 32] == EXIT) && msk[c][i] && !m_term[c][i];
                if (ev) begin
                    m_term[c][i] = 1'b1;
                    if (!m_fail[c] && tr[32*i +: 32] != 0) begin
                        m_fail[c] = 1; m_fid[c] = i; m_fcode[c] = tr[32*i +: 32];
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic step();
        compare_all();
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_in();
        tv = '0; ti = '0; tr = '0;
    endtask

    task automatic exit_core(int i, logic [31:0] code);
        tv[i] = 1'b1;
        ti[32*i +: 32] = EXIT;
        tr[32*i +: 32] = code;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int pv;
        int stop_at;
        rst = 1'b1;
        idle_in();
        msk[0] = 4'hF; msk[1] = 4'b0100; msk[2] = 4'hF;
        model_update();
        repeat (3) @(negedge clk);

        // S1: cores 0..3 exit cleanly at 10/20/30/40.
        do_reset();
        for (int t = 0; t <= 60; t++) begin
            idle_in();
            if (t == 10) exit_core(0, 0);
            if (t == 20) exit_core(1, 0);
            if (t == 30) exit_core(2, 0);
            if (t == 40) exit_core(3, 0);
            if (t == 0)  chk("s1_reset_state", 0, o_st[0], 0);
            if (t == 11) chk("s1_num_11", 0, o_num[0], 1);
            if (t == 21) chk("s1_num_21", 0, o_num[0], 2);
            if (t == 31) chk("s1_num_31", 0, o_num[0], 3);
            if (t == 41) chk("s1_num_41", 0, o_num[0], 4);
            if (t == 57) chk("s1_done_57", 0, o_done[0], 0);
            if (t == 58) chk("s1_done_58", 0, o_done[0], 1);
            if (t == 60) chk("s1_fail", 0, o_fail[0], 0);
            step();
        end

        // S2: cores 2 and 1 fail together, then core 3 fails later.
        do_reset();
        for (int t = 0; t <= 20; t++) begin
            idle_in();
            if (t == 5) begin exit_core(2, 5); exit_core(1, 7); end
            if (t == 12) exit_core(3, 9);
            if (t == 6) begin
                chk("s2_fail", 0, o_fail[0], 1);
                chk("s2_fail_id", 0, o_fid[0], 1);
                chk("s2_fail_code", 0, o_fcode[0], 7);
                chk("s2_mask_fail_id", 1, o_fid[1], 2);
                chk("s2_mask_fail_code", 1, o_fcode[1], 5);
            end
            if (t == 14) begin
                chk("s2_fail_id_kept", 0, o_fid[0], 1);
                chk("s2_fail_code_kept", 0, o_fcode[0], 7);
            end
            step();
        end

        // S3: any-mode, only core 2 masked in; core 0 exit must be ignored.
        do_reset();
        for (int t = 0; t <= 60; t++) begin
            idle_in();
            if (t == 10) exit_core(0, 3);
            if (t == 50) exit_core(2, 0);
            if (t == 53) exit_core(2, 4);
            if (t == 11) chk("s3_core0_ignored", 1, o_term[1], 0);
            if (t == 51) chk("s3_state_51", 1, o_st[1], 0);
            if (t == 52) chk("s3_state_52", 1, o_st[1], 1);
            if (t == 55) chk("s3_done_55", 1, o_done[1], 1);
            if (t == 58) chk("s3_code_kept", 1, o_fcode[1], 0);
            step();
        end

        // S4: watchdog after retire pulses stop at 30; mask=0 boundary on cfg2.
        msk[0] = 4'hF; msk[1] = 4'b0100; msk[2] = 4'h0;
        do_reset();
        for (int t = 0; t <= 140; t++) begin
            idle_in();
            if (t < 30) begin
                tv[0] = 1'b1;
                ti[31:0] = 32'hE000_0000 | 32'($urandom_range(0, 1000));
            end
            if (t == 135) exit_core(1, 0);
            if (t == 0)   chk("s4_mask0_state0", 2, o_st[2], 0);
            if (t == 1)   chk("s4_mask0_done1", 2, o_done[2], 1);
            if (t == 129) chk("s4_timeout_129", 0, o_to[0], 0);
            if (t == 130) chk("s4_timeout_130", 0, o_to[0], 1);
            if (t == 130) chk("s4_no_done", 0, o_done[0], 0);
            if (t == 136) chk("s4_late_exit", 0, o_term[0], 4'b0010);
            step();
        end

        // S6: reset in the middle of DRAIN discards everything.
        msk[0] = 4'hF; msk[1] = 4'hF; msk[2] = 4'hF;
        do_reset();
        for (int t = 0; t <= 8; t++) begin
            idle_in();
            if (t == 3) begin
                exit_core(0, 0); exit_core(1, 0); exit_core(2, 0); exit_core(3, 6);
            end
            if (t == 7) begin
                chk("s6_in_drain", 0, o_st[0], 1);
                chk("s6_fail_set", 0, o_fail[0], 1);
            end
            if (t == 8) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        idle_in();
        chk("s6_rst_state", 0, o_st[0], 0);
        chk("s6_rst_term", 0, o_term[0], 0);
        chk("s6_rst_num", 0, o_num[0], 0);
        chk("s6_rst_fail", 0, o_fail[0], 0);
        chk("s6_rst_code", 0, o_fcode[0], 0);
        step();

        // Randomized runs: random masks, activity rates and a point where retires stop.
        for (int run = 0; run < 10; run++) begin
            for (int c = 0; c < NCFG; c++) msk[c] = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: pv = 2;
                1: pv = 10;
                2: pv = 30;
                default: pv = 70;
            endcase
            stop_at = $urandom_range(40, 300);
            do_reset();
            for (int t = 0; t < 300; t++) begin
                idle_in();
                for (int i = 0; i < NC; i++) begin
                    if (t < stop_at && $urandom_range(0, 99) < pv) begin
                        tv[i] = 1'b1;
                        ti[32*i +: 32] = ($urandom_range(0, 2) == 0) ? EXIT : $urandom();
                        tr[32*i +: 32] = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'($urandom_range(1, 20));
                    end
                end
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
